dvi_video_sequencer: RTL and testbench

- Timing controller and pixel scheduler for the three TMDS channel encoders (blue/green/red) of the DVI transmitter.
- Generates raster counters, hsync/vsync/de and per-channel c0/c1.
- Pulls RGB pixels from a show-ahead pixel source (line/frame buffer FIFO) with a request handshake.
- Feeds registered, aligned din/de/c0/c1 to the encoders, substituting black and flagging underflow when the source is late.

---
 rtl/dvi_timing_pkg.sv | 32 +++
 rtl/dvi_video_sequencer_if.sv | 28 ++
 rtl/dvi_raster_counter.sv | 78 +++++++
 rtl/dvi_video_sequencer.sv | 124 ++++++++++++
 tb/tb_dvi_video_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_timing_pkg.sv
// Shared types and constants for the DVI video sequencer: FSM states, RGB packing
// and the default 1280x720 raster timing.
package dvi_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } seq_state_e;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    // Green/red channels never carry control-period signalling.
    localparam logic CTL_OFF = 1'b0;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam int DEF_CW       = 12;

    function automatic logic [7:0] rgb_field(input logic [23:0] pix, input int lsb);
        return pix[lsb +: 8];
    endfunction

endpackage

// File: rtl/dvi_video_sequencer_if.sv
// Pixel-source handshake and TMDS encoder feed of the DVI video sequencer.
interface dvi_video_sequencer_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_req;
    logic        enc_de;
    logic [7:0]  enc_b_din;
    logic [7:0]  enc_g_din;
    logic [7:0]  enc_r_din;
    logic        enc_b_c0;
    logic        enc_b_c1;
    logic        enc_g_c0;
    logic        enc_g_c1;
    logic        enc_r_c0;
    logic        enc_r_c1;

    modport master (
        input  pix_data, pix_valid,
        output pix_req, enc_de, enc_b_din, enc_g_din, enc_r_din,
               enc_b_c0, enc_b_c1, enc_g_c0, enc_g_c1, enc_r_c0, enc_r_c1
    );

    modport slave (
        output pix_data, pix_valid,
        input  pix_req, enc_de, enc_b_din, enc_g_din, enc_r_din,
               enc_b_c0, enc_b_c1, enc_g_c0, enc_g_c1, enc_r_c0, enc_r_c1
    );
endinterface

// File: rtl/dvi_raster_counter.sv
// Horizontal/vertical raster counters with wrap and active/sync region decode.
module dvi_raster_counter
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          in_active,
    output logic          in_hsync,
    output logic          in_vsync,
    output logic          at_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL >= (1 << CW)) begin : g_h_total_chk
        $error("H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL >= (1 << CW)) begin : g_v_total_chk
        $error("V_TOTAL does not fit in CW bits");
    end

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (advance) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    assign h_cnt     = h_q;
    assign v_cnt     = v_q;
    assign in_active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign in_hsync  = (h_q >= HS_BEG) && (h_q < HS_END);
    assign in_vsync  = (v_q >= VS_BEG) && (v_q < VS_END);
    assign at_wrap   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/dvi_video_sequencer.sv
// DVI timing controller: run/stop FSM, pixel pull from a show-ahead source and
// a one-clock registered stage feeding the three TMDS encoders.
//   state   | meaning
//   IDLE    | counters held at 0, outputs blank, syncs inactive
//   RUN     | raster advancing, frames repeat
//   STOP    | raster advancing until the current frame wraps, then IDLE
module dvi_video_sequencer
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = DEF_CW
) (
    input  logic                   clkin,
    input  logic                   rstin_n,
    input  logic                   en,
    input  logic                   underflow_clr,
    dvi_video_sequencer_if.master  vid,
    output logic                   frame_start,
    output logic                   underflow,
    output logic [CW-1:0]          h_cnt,
    output logic [CW-1:0]          v_cnt,
    output logic                   busy
);

    seq_state_e state_q, state_d;

    logic in_active, in_hsync, in_vsync, at_wrap;
    logic running, active;

    logic        de_q, de_d;
    logic [23:0] pix_q, pix_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic        uf_q, uf_d;

    dvi_raster_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CW       (CW)
    ) u_raster (
        .clk       (clkin),
        .rst_n     (rstin_n),
        .advance   (running),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .in_active (in_active),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .at_wrap   (at_wrap)
    );

    always_ff @(posedge clkin) begin
        if (!rstin_n) begin
            state_q <= ST_IDLE;
            de_q    <= 1'b0;
            pix_q   <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            de_q    <= de_d;
            pix_q   <= pix_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
        end
    end

    // Leaving IDLE does not advance the raster, so the first RUN clock sits at (0,0).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_STOP;
            ST_STOP: begin
                if (en)           state_d = ST_RUN;
                else if (at_wrap) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign running = (state_q != ST_IDLE);
    assign active  = in_active && running;

    always_comb begin
        de_d  = active;
        pix_d = (active && vid.pix_valid) ? vid.pix_data : '0;
        hs_d  = (running && in_hsync) ? HS_POL : ~HS_POL;
        vs_d  = (running && in_vsync) ? VS_POL : ~VS_POL;
        fs_d  = active && (h_cnt == '0) && (v_cnt == '0);
        uf_d  = (active && !vid.pix_valid) || (uf_q && !underflow_clr);
    end

    assign vid.pix_req   = active && vid.pix_valid;
    assign vid.enc_de    = de_q;
    assign vid.enc_b_din = rgb_field(pix_q, B_LSB);
    assign vid.enc_g_din = rgb_field(pix_q, G_LSB);
    assign vid.enc_r_din = rgb_field(pix_q, R_LSB);
    assign vid.enc_b_c0  = hs_q;
    assign vid.enc_b_c1  = vs_q;
    assign vid.enc_g_c0  = CTL_OFF;
    assign vid.enc_g_c1  = CTL_OFF;
    assign vid.enc_r_c0  = CTL_OFF;
    assign vid.enc_r_c1  = CTL_OFF;

    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign busy        = running;

endmodule

// File: tb/tb_dvi_video_sequencer.sv
// Bench for dvi_video_sequencer on a 7x5 raster: one instance with high sync
// polarity, one with low, both driven identically and checked against a model.
module tb_dvi_video_sequencer;

    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr;
    logic [CW-1:0] h_a, v_a, h_b, v_b;
    logic fs_a, fs_b, uf_a, uf_b, busy_a, busy_b;

    dvi_video_sequencer_if vif_a ();
    dvi_video_sequencer_if vif_b ();

    dvi_video_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut_a (
        .clkin(clk), .rstin_n(rst_n), .en(en), .underflow_clr(clr), .vid(vif_a),
        .frame_start(fs_a), .underflow(uf_a), .h_cnt(h_a), .v_cnt(v_a), .busy(busy_a)
    );

    dvi_video_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut_b (
        .clkin(clk), .rstin_n(rst_n), .en(en), .underflow_clr(clr), .vid(vif_b),
        .frame_start(fs_b), .underflow(uf_b), .h_cnt(h_b), .v_cnt(v_b), .busy(busy_b)
    );

    // Registered outputs as seen with active-high sync polarity.
    typedef struct packed {
        logic        de;
        logic [23:0] rgb;
        logic        bc0;
        logic        bc1;
        logic [3:0]  ctl;
        logic        fs;
        logic        uf;
    } reg_out_t;

    typedef struct {
        logic r;
        logic e;
        logic pv;
        logic c;
        int   cycles;
        int   exp_req;
        logic exp_busy;
    } row_t;

    reg_out_t exp_q[$];
    int total = 0;
    int bad   = 0;

    int          m_st;
    int          m_h;
    int          m_v;
    logic        m_uf;
    logic [23:0] next_pix;
    int          req_cnt;
    logic        last_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic reg_out_t grab_a();
        reg_out_t o;
        o.de  = vif_a.enc_de;
        o.rgb = {vif_a.enc_r_din, vif_a.enc_g_din, vif_a.enc_b_din};
        o.bc0 = vif_a.enc_b_c0;
        o.bc1 = vif_a.enc_b_c1;
        o.ctl = {vif_a.enc_g_c0, vif_a.enc_g_c1, vif_a.enc_r_c0, vif_a.enc_r_c1};
        o.fs  = fs_a;
        o.uf  = uf_a;
        return o;
    endfunction

    function automatic reg_out_t grab_b();
        reg_out_t o;
        o.de  = vif_b.enc_de;
        o.rgb = {vif_b.enc_r_din, vif_b.enc_g_din, vif_b.enc_b_din};
        o.bc0 = vif_b.enc_b_c0;
        o.bc1 = vif_b.enc_b_c1;
        o.ctl = {vif_b.enc_g_c0, vif_b.enc_g_c1, vif_b.enc_r_c0, vif_b.enc_r_c1};
        o.fs  = fs_b;
        o.uf  = uf_b;
        return o;
    endfunction

    task automatic pop_check();
        reg_out_t ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("regs_a", 64'(grab_a()), 64'(ex));
            ex.bc0 = ~ex.bc0;
            ex.bc1 = ~ex.bc1;
            check("regs_b", 64'(grab_b()), 64'(ex));
        end
    endtask

    // One clock: compare last cycle's registered outputs, drive inputs, compare
    // combinational outputs, queue the expected registered result, advance model.
    task automatic step(input logic r, input logic e, input logic pv, input logic c);
        reg_out_t ex;
        logic     act;
        logic     bsy;
        logic     wrap;
        pop_check();
        rst_n = r;
        en    = e;
        clr   = c;
        vif_a.pix_valid = pv;
        vif_b.pix_valid = pv;
        vif_a.pix_data  = pv ? next_pix : 24'hdeadbe;
        vif_b.pix_data  = pv ? next_pix : 24'hdeadbe;
        #1;
        act = (m_st != 0) && (m_h < HA) && (m_v < VA);
        bsy = (m_st != 0);
        check("pix_req", {62'd0, vif_a.pix_req, vif_b.pix_req}, {62'd0, act && pv, act && pv});
        check("pos", 64'({h_a, v_a, h_b, v_b, busy_a, busy_b}),
              64'({CW'(m_h), CW'(m_v), CW'(m_h), CW'(m_v), bsy, bsy}));
        last_busy = busy_a;
        if (act && pv) req_cnt++;
        ex = '0;
        if (!r) begin
            m_st = 0;
            m_h  = 0;
            m_v  = 0;
            m_uf = 1'b0;
        end else begin
            ex.de  = act;
            ex.rgb = (act && pv) ? next_pix : 24'h0;
            ex.bc0 = bsy && (m_h >= HA + HF) && (m_h < HA + HF + HS);
            ex.bc1 = bsy && (m_v >= VA + VF) && (m_v < VA + VF + VS);
            ex.fs  = act && (m_h == 0) && (m_v == 0);
            m_uf   = (act && !pv) || (m_uf && !c);
            ex.uf  = m_uf;
            if (act && pv) next_pix = next_pix + 24'd1;
            wrap = (m_h == HT - 1) && (m_v == VT - 1);
            if (m_st != 0) begin
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            case (m_st)
                0: if (e) m_st = 1;
                1: if (!e) m_st = 2;
                default: begin
                    if (e)         m_st = 1;
                    else if (wrap) m_st = 0;
                end
            endcase
        end
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(m_h == h && m_v == v) && n < 100) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end
        check("run_to_bound", 64'(n < 100), 64'd1);
    endtask

    row_t rows[6];

    initial begin
        rows[0] = '{r:1'b0, e:1'b0, pv:1'b1, c:1'b0, cycles:3,  exp_req:0,  exp_busy:1'b0};
        rows[1] = '{r:1'b1, e:1'b1, pv:1'b1, c:1'b0, cycles:71, exp_req:16, exp_busy:1'b1};
        rows[2] = '{r:1'b1, e:1'b0, pv:1'b1, c:1'b0, cycles:40, exp_req:8,  exp_busy:1'b0};
        rows[3] = '{r:1'b1, e:1'b1, pv:1'b1, c:1'b0, cycles:8,  exp_req:4,  exp_busy:1'b1};
        rows[4] = '{r:1'b1, e:1'b1, pv:1'b0, c:1'b0, cycles:7,  exp_req:0,  exp_busy:1'b1};
        rows[5] = '{r:1'b1, e:1'b1, pv:1'b1, c:1'b1, cycles:3,  exp_req:0,  exp_busy:1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        vif_a.pix_valid = 1'b0;
        vif_b.pix_valid = 1'b0;
        vif_a.pix_data  = '0;
        vif_b.pix_data  = '0;
        m_st = 0; m_h = 0; m_v = 0; m_uf = 1'b0;
        next_pix  = 24'd1;
        last_busy = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            req_cnt = 0;
            for (int k = 0; k < rows[i].cycles; k++)
                step(rows[i].r, rows[i].e, rows[i].pv, rows[i].c);
            check($sformatf("row%0d_req", i), 64'(req_cnt), 64'(rows[i].exp_req));
            check($sformatf("row%0d_busy", i), 64'(last_busy), 64'(rows[i].exp_busy));
        end

        // Source late on the third active pixel of a frame.
        run_to(0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("uf_set", 64'(uf_a), 64'd1);
        check("black_pixel", 64'({vif_a.enc_r_din, vif_a.enc_g_din, vif_a.enc_b_din}), 64'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("uf_sticky", 64'(uf_a), 64'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("uf_cleared", 64'(uf_a), 64'd0);

        // Reset in the middle of an active line, then restart.
        run_to(2, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_pos", 64'({h_a, v_a, busy_a, vif_a.enc_de}), 64'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("fs_restart", 64'({fs_a, fs_b}), 64'b11);

        // en dropped and re-raised mid-STOP: raster must not jump.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        pop_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
